// File: rtl/frame_spill_ctrl.sv
// frame_spill_ctrl: call/return sequencer for the register-file frame save path.
// A call snapshots the 16-word frame and spills it word by word to a downward-growing
// stack in data memory; a return refills the frame from the stack and pulses restore
// so the register file reloads it.
module frame_spill_ctrl #(
  parameter int          DATA_W     = 16,
  parameter int          NWORDS     = 16,
  parameter logic [15:0] STACK_BASE = 16'h7FFF,
  parameter int          MAX_DEPTH  = 8,
  parameter int          DEPTH_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       call,
  input  logic                       ret,
  input  logic [DATA_W*NWORDS-1:0]   fcOut,
  output logic [DATA_W*NWORDS-1:0]   fcIn,
  output logic                       restore,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [DEPTH_W-1:0]         depth,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [15:0]                mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack
);

  localparam int                 K_W    = $clog2(NWORDS);
  localparam logic [K_W-1:0]     K_LAST = K_W'(NWORDS - 1);
  localparam logic [15:0]        FRAME  = 16'(NWORDS);
  localparam logic [DEPTH_W-1:0] MAX_D  = DEPTH_W'(MAX_DEPTH);

  typedef enum logic [1:0] {IDLE, SPILL, FILL, RESTORE} state_t;

  state_t                     state, state_nxt;
  logic [K_W-1:0]             k;
  logic [15:0]                sp;
  logic [15:0]                k_ext;
  logic [DATA_W*NWORDS-1:0]   shadow;
  logic                       start_spill, start_fill, reject, last_word;

  // A simultaneous call and ret resolves to the call; a refused request only raises err.
  assign start_spill = (state == IDLE) && call && (depth < MAX_D);
  assign start_fill  = (state == IDLE) && ret && !call && (depth != '0);
  assign reject      = (state == IDLE) && (call || ret) && !start_spill && !start_fill;
  assign last_word   = mem_ack && (k == K_LAST);
  assign k_ext       = {{(16-K_W){1'b0}}, k};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and memory-port drive; the port is all zeros outside a transfer.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (start_spill)     state_nxt = SPILL;
        else if (start_fill) state_nxt = FILL;
      end
      SPILL: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp - k_ext;
        mem_wdata = shadow[k*DATA_W +: DATA_W];
        if (last_word) state_nxt = IDLE;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = sp + FRAME - k_ext;
        if (last_word) state_nxt = RESTORE;
      end
      RESTORE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign restore = (state == RESTORE);

  // Word index, stack pointer, depth and the completion/error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      sp    <= STACK_BASE;
      depth <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= ((state == SPILL) && last_word) || (state == RESTORE);
      err  <= reject;
      case (state)
        IDLE: k <= '0;
        SPILL: begin
          if (mem_ack) k <= k + 1'b1;
          if (last_word) begin
            sp    <= sp - FRAME;
            depth <= depth + 1'b1;
          end
        end
        FILL: if (mem_ack) k <= k + 1'b1;
        RESTORE: begin
          k     <= '0;
          sp    <= sp + FRAME;
          depth <= depth - 1'b1;
        end
        default: k <= '0;
      endcase
    end
  end

  // Frame snapshot taken on the accepting edge so later fcOut changes cannot leak in.
  always_ff @(posedge clk) begin
    if (start_spill) shadow <= fcOut;
  end

  // Restored frame is assembled word by word and held until the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        fcIn <= '0;
    else if (state == FILL && mem_ack) fcIn[k*DATA_W +: DATA_W] <= mem_rdata;
  end

endmodule
